csr_indptr_reader: RTL

- Consumer end of the CSR index-pointer FIFO (fifoindptr: 10-bit entries, 256 deep, registered read data).
- Pops consecutive indptr values and pairs indptr[i] with indptr[i+1].
- Emits one row descriptor per pair: row index, start offset, length. Descriptors go over a valid/ready handshake to the neighbour-fetch stage.
- A job is started by a pulse carrying the row count; done pulses once the last row is accepted.

---
 rtl/gnn_indptr_pkg.sv | 21 ++
 rtl/csr_indptr_reader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gnn_indptr_pkg.sv
// Shared types for the CSR indptr consumer.
// Default widths, FSM states and row descriptor layout.
package gnn_indptr_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_ROW_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [DEF_ROW_W-1:0]  row_idx;
    logic [DEF_DATA_W-1:0] row_start;
    logic [DEF_DATA_W-1:0] row_len;
  } row_desc_t;

endpackage

// File: rtl/csr_indptr_reader.sv
// Pops indptr[i], indptr[i+1] pairs from the FIFO and emits
// row descriptors (idx, start, len) over valid/ready.
module csr_indptr_reader
  import gnn_indptr_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROW_W  = DEF_ROW_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_empty,
  output logic              fifo_rdreq,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [ROW_W-1:0]  row_idx,
  output logic [DATA_W-1:0] row_start,
  output logic [DATA_W-1:0] row_len,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state;
  state_t            state_nx;
  logic              inflight;
  logic [DATA_W-1:0] prev;
  logic [ROW_W-1:0]  cnt;
  logic [ROW_W-1:0]  cnt_inc;
  logic [ROW_W-1:0]  nrows;
  logic              accept;
  logic              last_row;
  logic              mono;
  logic [DATA_W-1:0] diff;

  assign accept   = row_valid && row_ready;
  assign cnt_inc  = cnt + ROW_W'(1);
  assign last_row = (cnt_inc == nrows);
  assign mono     = (fifo_q >= prev);
  assign diff     = fifo_q - prev;

  // One read outstanding at most; RUN also waits for a free slot.
  always_comb begin
    state_nx   = state;
    fifo_rdreq = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && num_rows != '0)
          state_nx = FIRST;
      end
      FIRST: begin
        fifo_rdreq = !fifo_empty && !inflight;
        if (inflight)
          state_nx = RUN;
      end
      RUN: begin
        fifo_rdreq = !fifo_empty && !inflight
                     && (!row_valid || row_ready);
        if (inflight && last_row)
          state_nx = DRAIN;
      end
      DRAIN: begin
        if (accept)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight  <= 1'b0;
      prev      <= '0;
      cnt       <= '0;
      nrows     <= '0;
      row_valid <= 1'b0;
      row_idx   <= '0;
      row_start <= '0;
      row_len   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= fifo_rdreq;
      if (accept)
        row_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (num_rows != '0) begin
              nrows <= num_rows;
              cnt   <= '0;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FIRST: begin
          if (inflight)
            prev <= fifo_q;
        end
        RUN: begin
          // A capture overrides the accept-clear: no bubble.
          if (inflight) begin
            row_valid <= 1'b1;
            row_start <= prev;
            row_idx   <= cnt;
            prev      <= fifo_q;
            cnt       <= cnt_inc;
            row_len   <= mono ? diff : '0;
            if (!mono)
              err <= 1'b1;
          end
        end
        DRAIN: begin
          if (accept) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
